// File: rtl/uart_tx_cfg_if.sv
// Byte push handshake between the UDM command/response logic and the configurable UART transmitter.
interface uart_tx_cfg_if;
  logic [7:0] din_bi;
  logic       din_valid_i;
  logic       din_ready_o;

  modport master (
    output din_bi,
    output din_valid_i,
    input  din_ready_o
  );

  modport slave (
    input  din_bi,
    input  din_valid_i,
    output din_ready_o
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with input FIFO, 5-8 data bits, none/even/odd parity and 1 or 2 stop bits.
// Frames queued in the FIFO are sent back to back with no idle gap.
module uart_tx_cfg #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned BITPERIOD_W = 29
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   locked_i,
  input  logic [BITPERIOD_W-1:0] bitperiod_i,
  input  logic [1:0]             nbits_i,
  input  logic [1:0]             parity_i,
  input  logic                   stop2_i,
  uart_tx_cfg_if.slave           din_if,
  output logic                   fifo_empty_o,
  output logic                   busy_o,
  output logic                   tx_done_tick_o,
  output logic                   tx_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage; the extra pointer bit distinguishes full from empty
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = din_if.din_valid_i && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign din_if.din_ready_o = ~full;
  assign fifo_empty_o       = empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din_if.din_bi;
  end

  // Transmit datapath state
  state_e                 state_q;
  logic [BITPERIOD_W-1:0] bit_cnt_q;
  logic [2:0]             data_cnt_q;
  logic [2:0]             last_idx_q;
  logic                   stop_cnt_q;
  logic [7:0]             shreg_q;
  logic                   par_en_q, par_bit_q, stop2_q;
  logic                   tx_q, busy_q, tick_q;

  logic       bit_end, frame_end, can_start;
  logic [7:0] data_mask, head_masked;
  logic       head_par, par_en;

  assign bit_end   = (bit_cnt_q == bitperiod_i);
  assign frame_end = (state_q == StStop) && bit_end && (stop_cnt_q == stop2_q);
  assign can_start = !empty && locked_i;
  assign pop       = can_start && ((state_q == StIdle) || frame_end);

  // Unused high bits are cleared so they neither shift out nor affect parity
  always_comb begin
    data_mask   = 8'hFF >> (2'd3 - nbits_i);
    head_masked = head & data_mask;
    head_par    = (^head_masked) ^ (parity_i == 2'b10);
    par_en      = (parity_i == 2'b01) || (parity_i == 2'b10);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      data_cnt_q <= '0;
      last_idx_q <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (pop) begin
        // Start a frame, either from idle or directly off the last stop clock
        state_q    <= StStart;
        shreg_q    <= head_masked;
        last_idx_q <= {1'b1, nbits_i};
        par_en_q   <= par_en;
        par_bit_q  <= head_par;
        stop2_q    <= stop2_i;
        bit_cnt_q  <= '0;
        data_cnt_q <= '0;
        stop_cnt_q <= 1'b0;
        tx_q       <= 1'b0;
        busy_q     <= 1'b1;
        if (state_q == StStop) tick_q <= 1'b1;
      end else begin
        if (state_q != StIdle) begin
          bit_cnt_q <= bit_end ? '0 : bit_cnt_q + 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
          end
          StStart: begin
            if (bit_end) begin
              state_q <= StData;
              tx_q    <= shreg_q[0];
            end
          end
          StData: begin
            if (bit_end) begin
              if (data_cnt_q == last_idx_q) begin
                if (par_en_q) begin
                  state_q <= StParity;
                  tx_q    <= par_bit_q;
                end else begin
                  state_q <= StStop;
                  tx_q    <= 1'b1;
                end
              end else begin
                data_cnt_q <= data_cnt_q + 1'b1;
                shreg_q    <= shreg_q >> 1;
                tx_q       <= shreg_q[1];
              end
            end
          end
          StParity: begin
            if (bit_end) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
          end
          StStop: begin
            if (bit_end) begin
              if (stop_cnt_q == stop2_q) begin
                tick_q  <= 1'b1;
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                stop_cnt_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx_o           = tx_q;
  assign busy_o         = busy_q;
  assign tx_done_tick_o = tick_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized self-checking bench for uart_tx_cfg: a frame-level model predicts the line waveform
// and the handshake/status outputs on every clock.
module tb_uart_tx_cfg;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BPW   = 29;

  logic           clk_i       = 1'b0;
  logic           rstn_i      = 1'b0;
  logic           locked_i    = 1'b0;
  logic [BPW-1:0] bitperiod_i = '0;
  logic [1:0]     nbits_i     = 2'b11;
  logic [1:0]     parity_i    = 2'b00;
  logic           stop2_i     = 1'b0;
  logic           fifo_empty_o, busy_o, tx_done_tick_o, tx_o;

  uart_tx_cfg_if din_if ();

  uart_tx_cfg #(
    .FIFO_DEPTH (DEPTH),
    .BITPERIOD_W(BPW)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .locked_i      (locked_i),
    .bitperiod_i   (bitperiod_i),
    .nbits_i       (nbits_i),
    .parity_i      (parity_i),
    .stop2_i       (stop2_i),
    .din_if        (din_if.slave),
    .fifo_empty_o  (fifo_empty_o),
    .busy_o        (busy_o),
    .tx_done_tick_o(tx_done_tick_o),
    .tx_o          (tx_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes accepted but not yet started, and per-clock expected line levels
  logic [7:0]  pending[$];
  logic        exp_wave[$];
  bit          frame_active = 1'b0;
  bit          exp_tick     = 1'b0;
  int unsigned m_pre;
  bit          m_accept;
  logic        m_exp_tx;

  function automatic void build_frame(input logic [7:0] b, input logic [1:0] nb,
                                      input logic [1:0] par, input logic s2,
                                      input int unsigned bp);
    logic        lv[$];
    int unsigned n    = int'(nb) + 5;
    int unsigned ones = 0;
    lv.push_back(1'b0);
    for (int i = 0; i < int'(n); i++) begin
      lv.push_back(b[i]);
      ones += b[i];
    end
    if (par == 2'b01) lv.push_back((ones % 2) == 1);
    if (par == 2'b10) lv.push_back((ones % 2) == 0);
    for (int i = 0; i <= int'(s2); i++) lv.push_back(1'b1);
    foreach (lv[i]) begin
      for (int k = 0; k <= int'(bp); k++) exp_wave.push_back(lv[i]);
    end
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending.delete();
      exp_wave.delete();
      frame_active = 1'b0;
      exp_tick     = 1'b0;
    end else begin
      m_pre    = pending.size();
      m_accept = din_if.din_valid_i && (m_pre < DEPTH);
      exp_tick = 1'b0;
      if (frame_active && exp_wave.size() == 0) begin
        exp_tick     = 1'b1;
        frame_active = 1'b0;
      end
      if (m_pre > 0 && locked_i && exp_wave.size() == 0) begin
        build_frame(pending.pop_front(), nbits_i, parity_i, stop2_i, bitperiod_i);
        frame_active = 1'b1;
      end
      if (m_accept) pending.push_back(din_if.din_bi);
    end
  end

  always @(negedge clk_i) begin
    m_exp_tx = (exp_wave.size() > 0) ? exp_wave.pop_front() : 1'b1;
    check_eq("tx", tx_o, m_exp_tx);
    check_eq("busy", busy_o, frame_active);
    check_eq("tick", tx_done_tick_o, exp_tick);
    check_eq("empty", fifo_empty_o, pending.size() == 0);
    check_eq("ready", din_if.din_ready_o, pending.size() < DEPTH);
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk_i);
    #1;
    din_if.din_bi      = b;
    din_if.din_valid_i = 1'b1;
    @(negedge clk_i);
    #1;
    din_if.din_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned max_cyc);
    int unsigned c = 0;
    while (!(fifo_empty_o && !busy_o) && c < max_cyc) begin
      @(negedge clk_i);
      c++;
    end
    check_eq("drain", {31'b0, fifo_empty_o && !busy_o}, 32'd1);
  endtask

  task automatic set_cfg(input logic [1:0] nb, input logic [1:0] par, input logic s2);
    nbits_i  = nb;
    parity_i = par;
    stop2_i  = s2;
  endtask

  initial begin
    din_if.din_bi      = 8'h00;
    din_if.din_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1 rstn_i = 1'b1;
    check_eq("rst_tx", tx_o, 1'b1);
    check_eq("rst_ready", din_if.din_ready_o, 1'b1);
    check_eq("rst_empty", fifo_empty_o, 1'b1);

    // 8N1, 0xA5, 10 clocks per bit
    locked_i    = 1'b1;
    bitperiod_i = 9;
    set_cfg(2'b11, 2'b00, 1'b0);
    push_byte(8'hA5);
    wait_idle(300);

    // 7E2, 0x43, 4 clocks per bit
    bitperiod_i = 3;
    set_cfg(2'b10, 2'b01, 1'b1);
    push_byte(8'h43);
    wait_idle(200);

    // 5O1, 0xFF: upper bits never leave
    set_cfg(2'b00, 2'b10, 1'b0);
    push_byte(8'hFF);
    wait_idle(200);

    // Fill while unlocked; fifth byte is dropped, then drain back to back
    locked_i    = 1'b0;
    bitperiod_i = 2;
    set_cfg(2'b11, 2'b00, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i));
      if (i == 4) check_eq("full_ready", din_if.din_ready_o, 1'b0);
    end
    check_eq("full_empty", fifo_empty_o, 1'b0);
    repeat (5) @(negedge clk_i);
    check_eq("unlocked_tx", tx_o, 1'b1);
    locked_i = 1'b1;
    wait_idle(400);

    // Width change mid-frame only affects the queued frame
    bitperiod_i = 3;
    set_cfg(2'b11, 2'b00, 1'b0);
    push_byte(8'hA5);
    push_byte(8'hA5);
    repeat (10) @(negedge clk_i);
    #1 nbits_i = 2'b00;
    wait_idle(300);

    // Asynchronous reset in the middle of a data bit
    bitperiod_i = 4;
    set_cfg(2'b11, 2'b00, 1'b0);
    push_byte(8'h3C);
    push_byte(8'h11);
    repeat (16) @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    check_eq("arst_tx", tx_o, 1'b1);
    check_eq("arst_busy", busy_o, 1'b0);
    check_eq("arst_empty", fifo_empty_o, 1'b1);
    repeat (2) @(negedge clk_i);
    #1 rstn_i = 1'b1;
    repeat (30) @(negedge clk_i);
    check_eq("post_rst_tx", tx_o, 1'b1);

    // Randomized traffic, config changes and lock drops
    for (int g = 0; g < 6; g++) begin
      bitperiod_i = BPW'($urandom_range(0, 4));
      for (int k = 0; k < 8; k++) begin
        set_cfg(2'($urandom), 2'($urandom), 1'($urandom));
        locked_i = ($urandom_range(0, 3) != 0);
        push_byte(8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk_i);
      end
      #1 locked_i = 1'b1;
      wait_idle(2000);
    end

    repeat (5) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
